// File: rtl/mnacidpro_seq_pkg.sv
// mnacidpro_seq_pkg: shared state encoding, pump pattern, valve masks and stroke selection
// for the nucleic-acid purification sequencer.
package mnacidpro_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE, ST_LOAD, ST_LYSIS, ST_MIX, ST_BIND, ST_WASH, ST_ELUTE, ST_COLLECT, ST_SETTLE, ST_DONE
   } state_t;

   // {pump1,pump2,pump3} for steps 0..5 of one stroke
   localparam logic [2:0] PUMP_PAT [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

   // open-valve masks, bit order {dead_end,collection,bead_trap,bead_vtl,loop_exit,vertical,horiz,elute,wash,lysis}
   localparam logic [9:0] OPEN_LOAD    = 10'h210;
   localparam logic [9:0] OPEN_LYSIS   = 10'h011;
   localparam logic [9:0] OPEN_MIX     = 10'h008;
   localparam logic [9:0] OPEN_BIND    = 10'h048;
   localparam logic [9:0] OPEN_WASH    = 10'h0a2;
   localparam logic [9:0] OPEN_ELUTE   = 10'h084;
   localparam logic [9:0] OPEN_COLLECT = 10'h120;

   function automatic logic is_pump(input state_t s);
      return s inside {ST_LOAD, ST_LYSIS, ST_MIX, ST_BIND, ST_WASH, ST_ELUTE, ST_COLLECT};
   endfunction

   function automatic logic [9:0] open_mask(input state_t s);
      return s == ST_LOAD    ? OPEN_LOAD    :
             s == ST_LYSIS   ? OPEN_LYSIS   :
             s == ST_MIX     ? OPEN_MIX     :
             s == ST_BIND    ? OPEN_BIND    :
             s == ST_WASH    ? OPEN_WASH    :
             s == ST_ELUTE   ? OPEN_ELUTE   :
             s == ST_COLLECT ? OPEN_COLLECT : 10'h000;
   endfunction

   function automatic int unsigned stroke_sel(input state_t s, input int unsigned n_load, n_lysis,
                                              n_mix, n_bind, n_wash, n_elute, n_collect);
      return s == ST_LOAD  ? n_load  :
             s == ST_LYSIS ? n_lysis :
             s == ST_MIX   ? n_mix   :
             s == ST_BIND  ? n_bind  :
             s == ST_WASH  ? n_wash  :
             s == ST_ELUTE ? n_elute : n_collect;
   endfunction

endpackage

// File: rtl/peristaltic_phase_gen.sv
// peristaltic_phase_gen: phase/step/stroke counters and registered 3-phase pump pattern.
// restart with enable begins at step 0; restart without enable clears to pumps off.
module peristaltic_phase_gen
   import mnacidpro_seq_pkg::*;
#(
   parameter int PHASE_CYCLES = 4,
   parameter int STROKE_W     = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_restart,
   input  logic                i_enable,
   input  logic [STROKE_W-1:0] i_strokes,
   output logic [2:0]          o_pump,
   output logic                o_stroke_done
);

   localparam int PW = PHASE_CYCLES > 1 ? $clog2(PHASE_CYCLES) : 1;

   logic [PW-1:0]       r_phase, w_phase_nxt;
   logic [2:0]          r_step, w_step_nxt;
   logic [STROKE_W-1:0] r_stroke, w_stroke_nxt;
   logic [2:0]          r_pump;
   logic                w_phase_end, w_step_end, w_stroke_end;

   assign w_phase_end   = r_phase == PW'(PHASE_CYCLES - 1);
   assign w_step_end    = r_step == 3'd5;
   assign w_stroke_end  = r_stroke == i_strokes - STROKE_W'(1);
   assign o_stroke_done = w_phase_end && w_step_end && w_stroke_end;
   assign o_pump        = r_pump;

   always_comb begin
      w_phase_nxt  = r_phase;
      w_step_nxt   = r_step;
      w_stroke_nxt = r_stroke;
      if (i_restart) begin
         w_phase_nxt  = '0;
         w_step_nxt   = '0;
         w_stroke_nxt = '0;
      end else if (i_enable) begin
         w_phase_nxt  = w_phase_end ? '0 : r_phase + PW'(1);
         w_step_nxt   = !w_phase_end ? r_step : w_step_end ? 3'd0 : r_step + 3'd1;
         w_stroke_nxt = !(w_phase_end && w_step_end) ? r_stroke :
                        w_stroke_end ? '0 : r_stroke + STROKE_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase  <= '0;
         r_step   <= '0;
         r_stroke <= '0;
         r_pump   <= '0;
      end else begin
         r_phase  <= w_phase_nxt;
         r_step   <= w_step_nxt;
         r_stroke <= w_stroke_nxt;
         r_pump   <= i_enable ? PUMP_PAT[w_step_nxt] : i_restart ? 3'b000 : r_pump;
      end
   end

endmodule

// File: rtl/mnacidpro_sequencer.sv
// mnacidpro_sequencer: load/lysis/mix/bind/wash/elute/collect protocol driving valves and pumps.
// Define MNACIDPRO_SEQ_PAUSE_EN to add the i_pause freeze input.
module mnacidpro_sequencer
   import mnacidpro_seq_pkg::*;
#(
   parameter int          PUMP_PHASE_CYCLES = 4,
   parameter int          SETTLE_CYCLES     = 8,
   parameter int          STROKE_W          = 8,
   parameter int unsigned LOAD_STROKES      = 16,
   parameter int unsigned LYSIS_STROKES     = 16,
   parameter int unsigned MIX_STROKES       = 32,
   parameter int unsigned BIND_STROKES      = 16,
   parameter int unsigned WASH_STROKES      = 24,
   parameter int unsigned ELUTE_STROKES     = 8,
   parameter int unsigned COLLECT_STROKES   = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_abort,
`ifdef MNACIDPRO_SEQ_PAUSE_EN
   input  logic       i_pause,
`endif
   output logic       o_lysis_ctl,
   output logic       o_wash_ctl,
   output logic       o_elute_ctl,
   output logic       o_horiz_ctl,
   output logic       o_vertical_ctl,
   output logic       o_loop_exit_ctl,
   output logic       o_bead_vtl_ctl,
   output logic       o_bead_trap_ctl,
   output logic       o_collection_ctl,
   output logic       o_dead_end_ctl,
   output logic       o_pump1,
   output logic       o_pump2,
   output logic       o_pump3,
   output logic [3:0] o_stage,
   output logic       o_busy,
   output logic       o_done
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   state_t              r_state, w_state_nxt, r_prev;
   logic [SW-1:0]       r_settle;
   logic [9:0]          r_valve;
   logic                r_busy, r_done;
   logic                w_hold, w_stroke_done, w_settle_end, w_restart, w_enable;
   logic [STROKE_W-1:0] w_strokes;
   logic [2:0]          w_pump;

`ifdef MNACIDPRO_SEQ_PAUSE_EN
   assign w_hold = i_pause;
`else
   assign w_hold = 1'b0;
`endif

   assign w_strokes    = STROKE_W'(stroke_sel(r_state, LOAD_STROKES, LYSIS_STROKES, MIX_STROKES,
                                              BIND_STROKES, WASH_STROKES, ELUTE_STROKES, COLLECT_STROKES));
   assign w_settle_end = r_settle == SW'(SETTLE_CYCLES - 1);
   // any state change restarts the pump generator; only pumping stages leave it running
   assign w_restart    = w_state_nxt != r_state;
   assign w_enable     = is_pump(w_state_nxt) && !w_hold;

   peristaltic_phase_gen #(
      .PHASE_CYCLES (PUMP_PHASE_CYCLES),
      .STROKE_W     (STROKE_W)
   ) u_phase_gen (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_restart     (w_restart),
      .i_enable      (w_enable),
      .i_strokes     (w_strokes),
      .o_pump        (w_pump),
      .o_stroke_done (w_stroke_done)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort)
         w_state_nxt = ST_IDLE;
      else if (!w_hold) begin
         if (r_state == ST_IDLE || r_state == ST_DONE)
            w_state_nxt = i_start ? ST_LOAD : r_state;
         else if (r_state == ST_SETTLE)
            w_state_nxt = !w_settle_end ? r_state :
                          r_prev == ST_COLLECT ? ST_DONE : state_t'(r_prev + 4'd1);
         else if (w_stroke_done)
            w_state_nxt = ST_SETTLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_prev   <= ST_IDLE;
         r_settle <= '0;
         r_valve  <= '1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_prev   <= is_pump(r_state) ? r_state : r_prev;
         r_settle <= (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE) ? r_settle + SW'(!w_hold) : '0;
         r_valve  <= ~open_mask(w_state_nxt);
         r_busy   <= !(w_state_nxt inside {ST_IDLE, ST_DONE});
         r_done   <= w_state_nxt == ST_DONE;
      end
   end

   assign {o_dead_end_ctl, o_collection_ctl, o_bead_trap_ctl, o_bead_vtl_ctl, o_loop_exit_ctl,
           o_vertical_ctl, o_horiz_ctl, o_elute_ctl, o_wash_ctl, o_lysis_ctl} = r_valve;
   assign {o_pump1, o_pump2, o_pump3} = w_pump;
   assign o_stage = r_state;
   assign o_busy  = r_busy;
   assign o_done  = r_done;

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// tb_mnacidpro_sequencer: randomized and directed checks of the sequencer against a
// time-indexed reference model (PUMP_PHASE_CYCLES=2, SETTLE_CYCLES=3, all strokes 1).
module tb_mnacidpro_sequencer;

   localparam int PPC     = 2;
   localparam int SET     = 3;
   localparam int STG_LEN = 6 * PPC;
   localparam int SEG     = STG_LEN + SET;
   localparam int RUN     = 7 * SEG;
   localparam int T_DONE  = RUN + 1;
`ifdef MNACIDPRO_SEQ_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif
   localparam int LY = 0, WA = 1, EL = 2, HO = 3, VE = 4, LX = 5, BV = 6, BT = 7, CO = 8, DE = 9;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0;
   logic lysis, wash, elute, horiz, vertical, loop_exit, bead_vtl, bead_trap, collection, dead_end;
   logic pump1, pump2, pump3, busy, done;
   logic [3:0] stage;
   logic [18:0] obs;
   logic [2:0] pat_tab [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
   int checks = 0, failures = 0;
   int m_t = 0;

   always #5 clk = ~clk;

   mnacidpro_sequencer #(
      .PUMP_PHASE_CYCLES (PPC), .SETTLE_CYCLES (SET), .STROKE_W (8),
      .LOAD_STROKES (1), .LYSIS_STROKES (1), .MIX_STROKES (1), .BIND_STROKES (1),
      .WASH_STROKES (1), .ELUTE_STROKES (1), .COLLECT_STROKES (1)
   ) dut (
      .i_clk (clk), .i_rst_n (rst_n), .i_start (start), .i_abort (abort),
`ifdef MNACIDPRO_SEQ_PAUSE_EN
      .i_pause (pause),
`endif
      .o_lysis_ctl (lysis), .o_wash_ctl (wash), .o_elute_ctl (elute), .o_horiz_ctl (horiz),
      .o_vertical_ctl (vertical), .o_loop_exit_ctl (loop_exit), .o_bead_vtl_ctl (bead_vtl),
      .o_bead_trap_ctl (bead_trap), .o_collection_ctl (collection), .o_dead_end_ctl (dead_end),
      .o_pump1 (pump1), .o_pump2 (pump2), .o_pump3 (pump3),
      .o_stage (stage), .o_busy (busy), .o_done (done)
   );

   assign obs = {dead_end, collection, bead_trap, bead_vtl, loop_exit, vertical, horiz, elute, wash, lysis,
                 pump1, pump2, pump3, stage, busy, done};

   // open valves of pumping stage number seg (0 = LOAD .. 6 = COLLECT)
   function automatic logic [9:0] open_set(input int seg);
      logic [9:0] m;
      m = '0;
      case (seg)
         0: begin m[VE] = 1'b1; m[DE] = 1'b1; end
         1: begin m[LY] = 1'b1; m[VE] = 1'b1; end
         2: m[HO] = 1'b1;
         3: begin m[BV] = 1'b1; m[HO] = 1'b1; end
         4: begin m[WA] = 1'b1; m[BT] = 1'b1; m[LX] = 1'b1; end
         5: begin m[EL] = 1'b1; m[BT] = 1'b1; end
         default: begin m[CO] = 1'b1; m[LX] = 1'b1; end
      endcase
      return m;
   endfunction

   // t = 0 idle, 1..RUN = clocks since run start, T_DONE = done
   function automatic logic [18:0] exp_vec(input int t);
      logic [9:0] v;
      logic [2:0] p;
      logic [3:0] st;
      logic b, d;
      int seg, w;
      v = '1; p = '0; st = 4'd0; b = 1'b0; d = 1'b0;
      if (t == T_DONE) begin
         st = 4'd9; d = 1'b1;
      end else if (t > 0) begin
         b = 1'b1;
         seg = (t - 1) / SEG;
         w = (t - 1) % SEG;
         if (w < STG_LEN) begin
            st = 4'(seg + 1); p = pat_tab[w / PPC]; v = ~open_set(seg);
         end else st = 4'd8;
      end
      return {v, p, st, b, d};
   endfunction

   task automatic tick(input logic s, input logic a, input logic p);
      start = s; abort = a; pause = p;
      @(posedge clk);
      if (a) m_t = 0;
      else if (p && PAUSE_ON) m_t = m_t;
      else if (m_t == 0 || m_t == T_DONE) m_t = s ? 1 : m_t;
      else m_t++;
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (obs !== exp_vec(0)) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp_vec(0)); end
      rst_n = 1'b1;
      tick(1'b1, 1'b0, 1'b0);
      while (m_t < 4 * SEG + 3) tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (stage !== 4'd5) begin failures++; $display("FAIL reach_wash got=%0d exp=5", stage); end
      #2 rst_n = 1'b0;
      m_t = 0;
      #1;
      checks++;
      if (obs !== exp_vec(0)) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, exp_vec(0)); end
      tick(1'b1, 1'b0, 1'b0);
      m_t = 0;
      checks++;
      if (obs !== exp_vec(0)) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, exp_vec(0)); end
      rst_n = 1'b1;
   endtask

   task automatic test_full_run();
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL run_start got=%h exp=%h", obs, exp_vec(m_t)); end
      for (int i = 1; i <= RUN; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL run_edge%0d got=%h exp=%h", i, obs, exp_vec(m_t)); end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL done_at_105 got done=%b busy=%b exp done=1 busy=0", done, busy); end
      repeat (3) begin
         tick(1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL done_hold got=%h exp=%h", obs, exp_vec(m_t)); end
      end
   endtask

   task automatic test_abort();
      tick(1'b1, 1'b0, 1'b0);
      while (m_t < 5 * SEG + 4) tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (stage !== 4'd6) begin failures++; $display("FAIL reach_elute got=%0d exp=6", stage); end
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec(0) || m_t != 0) begin failures++; $display("FAIL abort_wins got=%h exp=%h", obs, exp_vec(0)); end
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if ({pump1, pump2, pump3} !== 3'b100 || stage !== 4'd1) begin
         failures++; $display("FAIL restart_load got pumps=%b stage=%0d exp pumps=100 stage=1", {pump1, pump2, pump3}, stage);
      end
      repeat (20) begin
         tick(1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL post_abort got=%h exp=%h", obs, exp_vec(m_t)); end
      end
   endtask

   task automatic test_start_held();
      int done_cnt;
      done_cnt = 0;
      tick(1'b0, 1'b1, 1'b0);
      repeat (RUN + 4) begin
         tick(1'b1, 1'b0, 1'b0);
         done_cnt += int'(done);
         checks++;
         if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL start_held got=%h exp=%h", obs, exp_vec(m_t)); end
      end
      checks++;
      if (done_cnt != 1) begin failures++; $display("FAIL done_one_cycle got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_pause();
      int edges;
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      edges = 0;
      while (m_t < 2 * SEG + 1 + 3 * PPC) begin tick(1'b0, 1'b0, 1'b0); edges++; end
      repeat (5) begin
         tick(1'b0, 1'b0, 1'b1);
         edges++;
         checks++;
         if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL pause_frozen got=%h exp=%h", obs, exp_vec(m_t)); end
      end
      while (done !== 1'b1 && edges < 300) begin
         tick(1'b0, 1'b0, 1'b0);
         edges++;
         checks++;
         if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL pause_resume got=%h exp=%h", obs, exp_vec(m_t)); end
      end
      checks++;
      if (edges != RUN + 5) begin failures++; $display("FAIL pause_run_len got=%0d exp=%0d", edges, RUN + 5); end
   endtask

   task automatic test_random();
      logic s, a, p;
      for (int i = 0; i < 1500; i++) begin
         s = ($urandom % 8) == 0;
         a = ($urandom % 90) == 0;
         p = PAUSE_ON && (($urandom % 6) == 0);
         tick(s, a, p);
         checks++;
         if (obs !== exp_vec(m_t)) begin failures++; $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_vec(m_t)); end
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_abort();
      test_start_held();
      if (PAUSE_ON) test_pause();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
